// File: rtl/twiddle_mul_384_if.sv
// rtl/twiddle_mul_384_if.sv - sample, ROM request/response and product signals of the twiddle multiplier
interface twiddle_mul_384_if #(
    parameter int D_WIDTH = 16,
    parameter int T_WIDTH = 16
);
    logic signed [D_WIDTH-1:0]   din_re;
    logic signed [D_WIDTH-1:0]   din_im;
    logic                        din_vld;
    logic                        din_sof;
    logic        [8:0]           rom_num;
    logic                        rom_vld;
    logic        [2*T_WIDTH-1:0] rom_dout;
    logic                        rom_dout_vld;
    logic signed [D_WIDTH-1:0]   dout_re;
    logic signed [D_WIDTH-1:0]   dout_im;
    logic                        dout_vld;
    logic                        dout_sof;
    logic                        dout_eof;
    logic                        err;

    modport master (
        output din_re, din_im, din_vld, din_sof, rom_dout, rom_dout_vld,
        input  rom_num, rom_vld, dout_re, dout_im, dout_vld, dout_sof, dout_eof, err
    );

    modport slave (
        input  din_re, din_im, din_vld, din_sof, rom_dout, rom_dout_vld,
        output rom_num, rom_vld, dout_re, dout_im, dout_vld, dout_sof, dout_eof, err
    );
endinterface

// File: rtl/twiddle_mul_384.sv
// rtl/twiddle_mul_384.sv - carrier counter, twiddle ROM requester and rounded/saturated complex multiplier
module twiddle_mul_384 #(
    parameter int D_WIDTH = 16,
    parameter int T_WIDTH = 16,
    parameter int N_CAR   = 384
) (
    input  logic              clk,
    input  logic              n_rst,
    twiddle_mul_384_if.slave  bus
);
    localparam int P_W  = D_WIDTH + T_WIDTH;
    localparam int S_W  = P_W + 2;
    localparam int FRAC = T_WIDTH - 2;
    localparam logic [8:0]           LAST = 9'(N_CAR - 1);
    localparam logic signed [S_W-1:0] MAXV = S_W'(2**(D_WIDTH-1) - 1);
    localparam logic signed [S_W-1:0] MINV = S_W'(-(2**(D_WIDTH-1)));

    typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

    state_t     state, state_nx;
    logic [8:0] cnt, cnt_nx;
    logic       accept, proto_err, tag_eof;

    logic signed [D_WIDTH-1:0] s1_re, s1_im;
    logic                      s1_vld, s1_sof, s1_eof;
    logic signed [T_WIDTH-1:0] tw_cos, tw_sin;
    logic signed [P_W-1:0]     p_rc, p_is, p_rs, p_ic;
    logic                      s2_vld, s2_sof, s2_eof;
    logic signed [S_W-1:0]     sum_re, sum_im;

    function automatic logic signed [D_WIDTH-1:0] round_sat(input logic signed [S_W-1:0] s);
        logic signed [S_W-1:0] r;
        r = (s + S_W'(2**(FRAC-1))) >>> FRAC;
        if (r > MAXV)
            return MAXV[D_WIDTH-1:0];
        else if (r < MINV)
            return MINV[D_WIDTH-1:0];
        else
            return r[D_WIDTH-1:0];
    endfunction

    // State and carrier counter register
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
        end
    end

    // Sample acceptance, symbol framing and protocol-error detection
    always_comb begin
        state_nx  = state;
        cnt_nx    = cnt;
        accept    = 1'b0;
        proto_err = 1'b0;
        tag_eof   = 1'b0;
        case (state)
            IDLE: begin
                if (bus.din_vld) begin
                    if (bus.din_sof) begin
                        accept   = 1'b1;
                        cnt_nx   = 9'd1;
                        state_nx = RUN;
                    end else begin
                        proto_err = 1'b1;
                    end
                end
            end
            RUN: begin
                if (bus.din_vld) begin
                    accept = 1'b1;
                    if (bus.din_sof) begin
                        // restart: the new sof sample becomes carrier 0 of a fresh symbol
                        proto_err = 1'b1;
                        cnt_nx    = 9'd1;
                    end else if (cnt == LAST) begin
                        tag_eof  = 1'b1;
                        cnt_nx   = '0;
                        state_nx = IDLE;
                    end else begin
                        cnt_nx = cnt + 9'd1;
                    end
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    assign bus.rom_vld = accept;
    assign bus.rom_num = bus.din_sof ? 9'd0 : cnt;

    assign tw_cos = $signed(bus.rom_dout[2*T_WIDTH-1:T_WIDTH]);
    assign tw_sin = $signed(bus.rom_dout[T_WIDTH-1:0]);

    // Stage 1: hold the sample while the ROM answers; flag errors and ROM/valid disagreement
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            s1_vld  <= 1'b0;
            s1_sof  <= 1'b0;
            s1_eof  <= 1'b0;
            s1_re   <= '0;
            s1_im   <= '0;
            bus.err <= 1'b0;
        end else begin
            s1_vld  <= accept;
            bus.err <= proto_err | (bus.rom_dout_vld != s1_vld);
            if (accept) begin
                s1_re  <= bus.din_re;
                s1_im  <= bus.din_im;
                s1_sof <= bus.din_sof;
                s1_eof <= tag_eof;
            end
        end
    end

    // Stage 2: the four partial products against the returned twiddle
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            s2_vld <= 1'b0;
            s2_sof <= 1'b0;
            s2_eof <= 1'b0;
            p_rc   <= '0;
            p_is   <= '0;
            p_rs   <= '0;
            p_ic   <= '0;
        end else begin
            s2_vld <= s1_vld;
            if (s1_vld) begin
                s2_sof <= s1_sof;
                s2_eof <= s1_eof;
                p_rc   <= s1_re * tw_cos;
                p_is   <= s1_im * tw_sin;
                p_rs   <= s1_re * tw_sin;
                p_ic   <= s1_im * tw_cos;
            end
        end
    end

    assign sum_re = S_W'(p_rc) - S_W'(p_is);
    assign sum_im = S_W'(p_rs) + S_W'(p_ic);

    // Stage 3: round, saturate and present; data holds while no product is valid
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            bus.dout_vld <= 1'b0;
            bus.dout_sof <= 1'b0;
            bus.dout_eof <= 1'b0;
            bus.dout_re  <= '0;
            bus.dout_im  <= '0;
        end else begin
            bus.dout_vld <= s2_vld;
            bus.dout_sof <= s2_vld & s2_sof;
            bus.dout_eof <= s2_vld & s2_eof;
            if (s2_vld) begin
                bus.dout_re <= round_sat(sum_re);
                bus.dout_im <= round_sat(sum_im);
            end
        end
    end
endmodule
